// File: rtl/video_out_fetch.sv
// Frame fetch engine: reads a frame over Wishbone in bursts and streams the words into a pixel FIFO.
// Optional VIDEO_OUT_FETCH_ERR_EN: ERR_I aborts a burst, which is retried from the faulting word.
module video_out_fetch #(
   parameter int unsigned FRAME_WORDS = 76800,
   parameter int unsigned BURST       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_reg_data,
   input  logic [31:0] wb_reg_ctr,
   input  logic [7:0]  fifo_free,
   output logic        fifo_wr,
   output logic [31:0] fifo_data,
   output logic        interrupt,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic        p_wb_WE_O,
   output logic [31:0] p_wb_ADR_O,
   input  logic [31:0] p_wb_DAT_I,
   input  logic        p_wb_ACK_I,
   input  logic        p_wb_ERR_I
);

   localparam int unsigned RemW  = ($clog2(FRAME_WORDS + 1) > 17) ? $clog2(FRAME_WORDS + 1) : 17;
   localparam int unsigned BeatW = $clog2(BURST + 1);

   typedef enum logic [1:0] {StIdle, StWaitSpace, StBurst, StEndFrame} state_e;

   state_e           state_q;
   logic [31:0]      base_q;
   logic [31:0]      addr_q;
   logic [RemW-1:0]  remaining_q;
   logic [BeatW-1:0] beats_q;

   logic             run;
   logic             space_ok;
   logic             start_frame;
   logic             err_abort;
   logic [BeatW-1:0] burst_len;

   assign run       = wb_reg_ctr[0];
   assign space_ok  = 32'(fifo_free) >= BURST;
   assign burst_len = (32'(remaining_q) < BURST) ? remaining_q[BeatW-1:0] : BeatW'(BURST);

   // A new frame starts from IDLE or straight out of END_FRAME while run is held.
   assign start_frame = run && ((state_q == StIdle) || (state_q == StEndFrame));

`ifdef VIDEO_OUT_FETCH_ERR_EN
   assign err_abort = p_wb_ERR_I;
`else
   assign err_abort = 1'b0;
   logic unused_err;
   assign unused_err = p_wb_ERR_I;
`endif

   // The base register only records where the current frame began.
   logic unused_sigs;
   assign unused_sigs = ^{wb_reg_ctr[31:1], base_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         base_q      <= 32'd0;
         addr_q      <= 32'd0;
         remaining_q <= '0;
         beats_q     <= '0;
         fifo_wr     <= 1'b0;
         fifo_data   <= 32'd0;
         interrupt   <= 1'b0;
         p_wb_CYC_O  <= 1'b0;
         p_wb_STB_O  <= 1'b0;
         p_wb_LOCK_O <= 1'b0;
         p_wb_SEL_O  <= 4'h0;
         p_wb_WE_O   <= 1'b0;
         p_wb_ADR_O  <= 32'd0;
      end else begin
         fifo_wr   <= 1'b0;
         interrupt <= 1'b0;

         if (start_frame) begin
            base_q      <= wb_reg_data;
            addr_q      <= wb_reg_data;
            remaining_q <= RemW'(FRAME_WORDS);
         end

         unique case (state_q)
            StIdle, StEndFrame: begin
               state_q <= run ? StWaitSpace : StIdle;
            end

            StWaitSpace: begin
               if (!run) begin
                  state_q <= StIdle;
               end else if (space_ok) begin
                  state_q     <= StBurst;
                  beats_q     <= burst_len;
                  p_wb_CYC_O  <= 1'b1;
                  p_wb_STB_O  <= 1'b1;
                  p_wb_LOCK_O <= 1'b1;
                  p_wb_SEL_O  <= 4'hF;
                  p_wb_ADR_O  <= addr_q;
               end
            end

            StBurst: begin
               if (err_abort) begin
                  // Unacknowledged word stays pending; address and count are untouched.
                  state_q     <= StWaitSpace;
                  p_wb_CYC_O  <= 1'b0;
                  p_wb_STB_O  <= 1'b0;
                  p_wb_LOCK_O <= 1'b0;
                  p_wb_SEL_O  <= 4'h0;
               end else if (p_wb_ACK_I) begin
                  fifo_wr     <= 1'b1;
                  fifo_data   <= p_wb_DAT_I;
                  addr_q      <= addr_q + 32'd4;
                  p_wb_ADR_O  <= addr_q + 32'd4;
                  remaining_q <= remaining_q - RemW'(1);
                  beats_q     <= beats_q - BeatW'(1);
                  if (beats_q == BeatW'(1)) begin
                     p_wb_CYC_O  <= 1'b0;
                     p_wb_STB_O  <= 1'b0;
                     p_wb_LOCK_O <= 1'b0;
                     p_wb_SEL_O  <= 4'h0;
                     if (remaining_q == RemW'(1)) begin
                        state_q   <= StEndFrame;
                        interrupt <= 1'b1;
                     end else begin
                        state_q <= run ? StWaitSpace : StIdle;
                     end
                  end
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_video_out_fetch.sv
// Bench for video_out_fetch: Wishbone slave model, bus monitor and an address/data scoreboard.
module tb_video_out_fetch;

`ifdef VIDEO_OUT_FETCH_ERR_EN
   localparam bit ErrAbort = 1'b1;
`else
   localparam bit ErrAbort = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [31:0] wb_reg_data;
   logic [31:0] ctr_a;
   logic [31:0] ctr_b;
   logic [7:0]  fifo_free;

   logic        wr_a, irq_a, stb_a, cyc_a, lock_a, we_a, ack_a, err_a, acc_a;
   logic [31:0] fdata_a, adr_a, dat_a;
   logic [3:0]  sel_a;
   logic        wr_b, irq_b, stb_b, cyc_b, lock_b, we_b, ack_b;
   logic [31:0] fdata_b, adr_b, dat_b;
   logic [3:0]  sel_b;

   logic        ack_en;
   logic        stray_ack;
   logic        err_armed;
   logic        err_hit;
   logic        err_seen = 1'b0;
   logic [31:0] err_addr;

   int checks = 0;
   int fails  = 0;

   logic [31:0] ack_q[$];
   logic [31:0] wr_q[$];
   logic [31:0] start_q[$];
   int          len_q[$];
   logic [31:0] exp_q[$];
   int irq_cnt = 0, wr_timing_err = 0, proto_err = 0, beat_cnt = 0;
   logic acc_prev = 1'b0, cyc_prev = 1'b0;

   logic [31:0] start_b_q[$];
   int          len_b_q[$];
   int irq_b_cnt = 0, wr_b_cnt = 0, beat_b_cnt = 0;
   logic cyc_b_prev = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   video_out_fetch #(.FRAME_WORDS(16), .BURST(8)) dut (
      .clk(clk), .rst(rst), .wb_reg_data(wb_reg_data), .wb_reg_ctr(ctr_a),
      .fifo_free(fifo_free), .fifo_wr(wr_a), .fifo_data(fdata_a), .interrupt(irq_a),
      .p_wb_STB_O(stb_a), .p_wb_CYC_O(cyc_a), .p_wb_LOCK_O(lock_a), .p_wb_SEL_O(sel_a),
      .p_wb_WE_O(we_a), .p_wb_ADR_O(adr_a), .p_wb_DAT_I(dat_a), .p_wb_ACK_I(ack_a),
      .p_wb_ERR_I(err_a)
   );

   video_out_fetch #(.FRAME_WORDS(10), .BURST(8)) dut10 (
      .clk(clk), .rst(rst), .wb_reg_data(wb_reg_data), .wb_reg_ctr(ctr_b),
      .fifo_free(fifo_free), .fifo_wr(wr_b), .fifo_data(fdata_b), .interrupt(irq_b),
      .p_wb_STB_O(stb_b), .p_wb_CYC_O(cyc_b), .p_wb_LOCK_O(lock_b), .p_wb_SEL_O(sel_b),
      .p_wb_WE_O(we_b), .p_wb_ADR_O(adr_b), .p_wb_DAT_I(dat_b), .p_wb_ACK_I(ack_b),
      .p_wb_ERR_I(1'b0)
   );

   // Slave models: zero-wait ACK, data derived from the address, one-shot ERR at err_addr.
   assign err_hit = err_armed & ~err_seen & cyc_a & stb_a & (adr_a == err_addr);
   assign err_a   = err_hit;
   assign ack_a   = (cyc_a & stb_a & ack_en & ~(err_hit & ErrAbort)) | stray_ack;
   assign acc_a   = ack_a & cyc_a & stb_a;
   assign dat_a   = pat(adr_a);
   assign ack_b   = cyc_b & stb_b;
   assign dat_b   = pat(adr_b);

   always @(posedge clk) err_seen <= err_armed & (err_seen | err_hit);

   always @(negedge clk) begin
      if (rst) begin
         acc_prev   <= 1'b0;
         cyc_prev   <= 1'b0;
         beat_cnt   <= 0;
         cyc_b_prev <= 1'b0;
         beat_b_cnt <= 0;
      end else begin
         if (wr_a !== acc_prev) wr_timing_err <= wr_timing_err + 1;
         if (wr_a) wr_q.push_back(fdata_a);
         if (cyc_a && !cyc_prev) start_q.push_back(adr_a);
         if (acc_a) begin
            ack_q.push_back(adr_a);
            beat_cnt <= beat_cnt + 1;
         end
         if (!cyc_a && cyc_prev) begin
            len_q.push_back(beat_cnt);
            beat_cnt <= 0;
         end
         if (irq_a) irq_cnt <= irq_cnt + 1;
         if (cyc_a && ({stb_a, lock_a, we_a, sel_a} !== 7'b1101111)) proto_err <= proto_err + 1;
         if (!cyc_a && ({stb_a, lock_a, we_a} !== 3'b000)) proto_err <= proto_err + 1;
         acc_prev <= acc_a;
         cyc_prev <= cyc_a;

         if (cyc_b && !cyc_b_prev) start_b_q.push_back(adr_b);
         if (ack_b) beat_b_cnt <= beat_b_cnt + 1;
         if (!cyc_b && cyc_b_prev) begin
            len_b_q.push_back(beat_b_cnt);
            beat_b_cnt <= 0;
         end
         if (irq_b) irq_b_cnt <= irq_b_cnt + 1;
         if (wr_b) wr_b_cnt <= wr_b_cnt + 1;
         cyc_b_prev <= cyc_b;
      end
   end

   task automatic clear_sb();
      ack_q.delete(); wr_q.delete(); start_q.delete(); len_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; ctr_a = 0; ctr_b = 0; wb_reg_data = 0; fifo_free = 0;
      ack_en = 1'b1; stray_ack = 1'b0; err_armed = 1'b0; err_addr = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cyc_a, stb_a, lock_a, we_a, sel_a} !== 8'h00) begin
         fails++; $display("FAIL reset_bus: got %b want 00000000", {cyc_a, stb_a, lock_a, we_a, sel_a});
      end
      checks++;
      if (adr_a !== 32'd0 || fdata_a !== 32'd0) begin
         fails++; $display("FAIL reset_regs: adr %h data %h want 0 0", adr_a, fdata_a);
      end
      checks++;
      if ({wr_a, irq_a} !== 2'b00) begin
         fails++; $display("FAIL reset_strobes: got %b want 00", {wr_a, irq_a});
      end
      @(posedge clk); #1 rst = 1'b0;
      clear_sb();
      stray_ack = 1'b1;
      repeat (4) @(posedge clk);
      #1 stray_ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_q.size() != 0 || cyc_a !== 1'b0) begin
         fails++; $display("FAIL stray_ack: %0d writes cyc %b want 0 writes cyc 0", wr_q.size(), cyc_a);
      end
   endtask

   task automatic test_frame16();
      logic [31:0] e, a, d;
      int irq0, te0, pe0;
      bit ok, moved;
      clear_sb();
      irq0 = irq_cnt; te0 = wr_timing_err; pe0 = proto_err;
      for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
      @(posedge clk); #1;
      wb_reg_data = 32'h1000; fifo_free = 8'd32; ctr_a = 1;
      ok = 0; moved = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cyc_a && !moved) begin
            wb_reg_data = 32'hDEAD_0000;  // mid-frame base change must not take effect
            moved = 1;
         end
         if (irq_a) begin ok = 1; ctr_a = 0; break; end
      end
      checks++;
      if (!ok) begin fails++; $display("FAIL f16_irq_timeout: no interrupt in 200 cycles"); end
      repeat (6) @(negedge clk);
      checks++;
      if (irq_cnt - irq0 != 1) begin
         fails++; $display("FAIL f16_irq_width: %0d cycles want 1", irq_cnt - irq0);
      end
      checks++;
      if (start_q.size() != 2 || start_q[0] !== 32'h1000 || start_q[1] !== 32'h1020) begin
         fails++; $display("FAIL f16_starts: n=%0d %h %h want 2 00001000 00001020",
                           start_q.size(), start_q[0], start_q[1]);
      end
      checks++;
      if (len_q.size() != 2 || len_q[0] != 8 || len_q[1] != 8) begin
         fails++; $display("FAIL f16_lens: n=%0d %0d %0d want 2 8 8", len_q.size(), len_q[0], len_q[1]);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (ack_q.size() > 0) ? ack_q.pop_front() : 32'hxxxx_xxxx;
         d = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hxxxx_xxxx;
         checks++;
         if (a !== e || d !== pat(e)) begin
            fails++; $display("FAIL f16_beat: adr %h data %h want adr %h data %h", a, d, e, pat(e));
         end
      end
      checks++;
      if (ack_q.size() != 0 || wr_q.size() != 0) begin
         fails++; $display("FAIL f16_extra: %0d acks %0d writes left want 0 0", ack_q.size(), wr_q.size());
      end
      checks++;
      if (wr_timing_err != te0 || proto_err != pe0) begin
         fails++; $display("FAIL f16_timing: wr_timing %0d proto %0d want 0 0",
                           wr_timing_err - te0, proto_err - pe0);
      end
   endtask

   task automatic test_frame10();
      int irq0, wr0;
      bit ok;
      irq0 = irq_b_cnt; wr0 = wr_b_cnt;
      start_b_q.delete(); len_b_q.delete();
      @(posedge clk); #1;
      wb_reg_data = 32'h8000; fifo_free = 8'd32; ctr_b = 1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (irq_b) begin ok = 1; ctr_b = 0; break; end
      end
      checks++;
      if (!ok) begin fails++; $display("FAIL f10_irq_timeout: no interrupt in 200 cycles"); end
      repeat (6) @(negedge clk);
      checks++;
      if (start_b_q.size() != 2 || start_b_q[0] !== 32'h8000 || start_b_q[1] !== 32'h8020) begin
         fails++; $display("FAIL f10_starts: n=%0d %h %h want 2 00008000 00008020",
                           start_b_q.size(), start_b_q[0], start_b_q[1]);
      end
      checks++;
      if (len_b_q.size() != 2 || len_b_q[0] != 8 || len_b_q[1] != 2) begin
         fails++; $display("FAIL f10_lens: n=%0d %0d %0d want 2 8 2", len_b_q.size(), len_b_q[0], len_b_q[1]);
      end
      checks++;
      if (wr_b_cnt - wr0 != 10 || irq_b_cnt - irq0 != 1) begin
         fails++; $display("FAIL f10_counts: writes %0d irq %0d want 10 1", wr_b_cnt - wr0, irq_b_cnt - irq0);
      end
   endtask

   task automatic test_fifo_space();
      logic [31:0] e, a, d;
      int irq0;
      bit ok;
      clear_sb();
      irq0 = irq_cnt;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h2000 + 32'(4 * i));
      @(posedge clk); #1;
      wb_reg_data = 32'h2000; fifo_free = 8'd7; ctr_a = 1;
      repeat (12) @(negedge clk);
      checks++;
      if (start_q.size() != 0 || cyc_a !== 1'b0) begin
         fails++; $display("FAIL space_hold: %0d bursts cyc %b want 0 0", start_q.size(), cyc_a);
      end
      @(posedge clk); #1 fifo_free = 8'd8;
      ok = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (cyc_a) begin ok = 1; break; end
      end
      checks++;
      if (!ok || adr_a !== 32'h2000) begin
         fails++; $display("FAIL space_start: started %0d adr %h want 1 00002000", ok, adr_a);
      end
      ctr_a = 0;
      repeat (16) @(negedge clk);
      checks++;
      if (len_q.size() != 1 || len_q[0] != 8 || irq_cnt != irq0) begin
         fails++; $display("FAIL space_burst: n=%0d len %0d irq %0d want 1 8 0",
                           len_q.size(), len_q[0], irq_cnt - irq0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (ack_q.size() > 0) ? ack_q.pop_front() : 32'hxxxx_xxxx;
         d = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hxxxx_xxxx;
         checks++;
         if (a !== e || d !== pat(e)) begin
            fails++; $display("FAIL space_beat: adr %h data %h want adr %h data %h", a, d, e, pat(e));
         end
      end
   endtask

   task automatic test_stop_mid_burst();
      logic [31:0] e, a, d;
      int irq0, n;
      bit ok;
      clear_sb();
      irq0 = irq_cnt;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h3000 + 32'(4 * i));
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h4000 + 32'(4 * i));
      @(posedge clk); #1;
      wb_reg_data = 32'h3000; fifo_free = 8'd32; ctr_a = 1;
      n = 0; ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (acc_a) n++;
         if (n == 3) begin ctr_a = 0; ok = 1; break; end
      end
      checks++;
      if (!ok) begin fails++; $display("FAIL stop_timeout: saw %0d acks want 3", n); end
      repeat (20) @(negedge clk);
      checks++;
      if (start_q.size() != 1 || len_q.size() != 1 || len_q[0] != 8 || cyc_a !== 1'b0) begin
         fails++; $display("FAIL stop_finish: bursts %0d len %0d cyc %b want 1 8 0",
                           start_q.size(), len_q[0], cyc_a);
      end
      wb_reg_data = 32'h4000; ctr_a = 1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cyc_a) begin ok = 1; ctr_a = 0; break; end
      end
      checks++;
      if (!ok || adr_a !== 32'h4000) begin
         fails++; $display("FAIL stop_restart: started %0d adr %h want 1 00004000", ok, adr_a);
      end
      repeat (16) @(negedge clk);
      checks++;
      if (irq_cnt != irq0 || len_q.size() != 2 || len_q[1] != 8) begin
         fails++; $display("FAIL stop_irq: irq %0d bursts %0d want 0 2", irq_cnt - irq0, len_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (ack_q.size() > 0) ? ack_q.pop_front() : 32'hxxxx_xxxx;
         d = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hxxxx_xxxx;
         checks++;
         if (a !== e || d !== pat(e)) begin
            fails++; $display("FAIL stop_beat: adr %h data %h want adr %h data %h", a, d, e, pat(e));
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      bit ok;
      clear_sb();
      @(posedge clk); #1;
      wb_reg_data = 32'h5000; fifo_free = 8'd32; ctr_a = 1;
      n = 0; ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (acc_a) n++;
         if (n == 2) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin fails++; $display("FAIL rst_timeout: saw %0d acks want 2", n); end
      @(posedge clk); #2;
      checks++;
      if ({cyc_a, wr_a} !== 2'b11) begin
         fails++; $display("FAIL rst_pre: cyc/wr %b want 11", {cyc_a, wr_a});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({cyc_a, stb_a, lock_a, wr_a} !== 4'b0000) begin
         fails++; $display("FAIL rst_async: cyc/stb/lock/wr %b want 0000", {cyc_a, stb_a, lock_a, wr_a});
      end
      checks++;
      if (adr_a !== 32'd0 || fdata_a !== 32'd0) begin
         fails++; $display("FAIL rst_async_regs: adr %h data %h want 0 0", adr_a, fdata_a);
      end
      ctr_a = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (wr_q.size() != 1 || ack_q.size() != 2 || cyc_a !== 1'b0) begin
         fails++; $display("FAIL rst_after: writes %0d acks %0d cyc %b want 1 2 0",
                           wr_q.size(), ack_q.size(), cyc_a);
      end
      checks++;
      if (wr_q.size() == 0 || wr_q[0] !== pat(32'h5000)) begin
         fails++; $display("FAIL rst_word: got %h want %h", wr_q[0], pat(32'h5000));
      end
   endtask

   task automatic test_err();
      logic [31:0] e, a, d;
      logic [31:0] es[3];
      int el[3];
      int nb, irq0;
      bit ok;
      clear_sb();
      irq0 = irq_cnt;
      if (ErrAbort) begin
         nb = 3; es = '{32'h1000, 32'h100C, 32'h102C}; el = '{3, 8, 5};
      end else begin
         nb = 2; es = '{32'h1000, 32'h1020, 32'h0}; el = '{8, 8, 0};
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
      @(posedge clk); #1;
      err_addr = 32'h100C; err_armed = 1'b1;
      wb_reg_data = 32'h1000; fifo_free = 8'd32; ctr_a = 1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (irq_a) begin ok = 1; ctr_a = 0; break; end
      end
      checks++;
      if (!ok) begin fails++; $display("FAIL err_irq_timeout: no interrupt in 300 cycles"); end
      err_armed = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         checks++;
         if (start_q.size() != nb || start_q[i] !== es[i] || len_q[i] != el[i]) begin
            fails++; $display("FAIL err_burst%0d: n=%0d start %h len %0d want %0d %h %0d",
                              i, start_q.size(), start_q[i], len_q[i], nb, es[i], el[i]);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = (ack_q.size() > 0) ? ack_q.pop_front() : 32'hxxxx_xxxx;
         d = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hxxxx_xxxx;
         checks++;
         if (a !== e || d !== pat(e)) begin
            fails++; $display("FAIL err_beat: adr %h data %h want adr %h data %h", a, d, e, pat(e));
         end
      end
      checks++;
      if (wr_q.size() != 0 || irq_cnt - irq0 != 1) begin
         fails++; $display("FAIL err_tail: extra writes %0d irq %0d want 0 1", wr_q.size(), irq_cnt - irq0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_frame16();
      test_frame10();
      test_fifo_space();
      test_stop_mid_burst();
      test_reset_mid_burst();
      test_err();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
